// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller. Handles load-use stalls, taken
//            branch flushes and data-memory freezes. A branch resolved while
//            the pipeline is frozen is remembered and its flush is replayed
//            after the freeze ends. The block also keeps saturating stall and
//            flush event counters and a sticky freeze watchdog.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            IDEX_MemRead/rd   - load in EX and its destination register
//            IFID_rs1/rs2      - ID source registers (rs2 valid if use_rs2)
//            branch_taken      - EX resolved a taken branch/jump this cycle
//            dmem_busy         - data memory not ready, pipeline holds
//            PC_write, IFID_write, IFID_flush, IDEX_flush, freeze
//                              - combinational pipeline controls
//            stall_cnt, flush_cnt - saturating event counters (CNT_W bits)
//            timeout           - sticky flag, freeze lasted MAX_FREEZE cycles
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int CNT_W      = 16,
  parameter int MAX_FREEZE = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_rd,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic             IFID_use_rs2,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_REPLAY = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
  localparam logic [7:0]       C_MAX_FREEZE = 8'(MAX_FREEZE);

  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [7:0]       frun_q, frun_d;
  logic             timeout_q, timeout_d;

  logic             load_use;
  logic             do_branch;
  logic             do_stall;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign load_use = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                    ((IDEX_rd == IFID_rs1) ||
                     (IFID_use_rs2 && (IDEX_rd == IFID_rs2)));

  // --------------------------------------------------------------------------
  // Control outputs and next state
  // --------------------------------------------------------------------------
  always_comb begin
    PC_write   = 1'b0;
    IFID_write = 1'b0;
    IFID_flush = 1'b0;
    IDEX_flush = 1'b0;
    freeze     = 1'b0;
    do_branch  = 1'b0;
    do_stall   = 1'b0;
    state_d    = state_q;
    pend_d     = pend_q;

    if (rst) begin
      // All controls low while in reset; state is cleared by the flops.
      state_d = ST_RUN;
      pend_d  = 1'b0;
    end else if (dmem_busy) begin
      // Memory stall dominates everything; a branch seen now is deferred.
      freeze  = 1'b1;
      state_d = ST_FREEZE;
      pend_d  = (state_q == ST_RUN) ? branch_taken : (pend_q | branch_taken);
    end else if (state_q == ST_REPLAY) begin
      // Replay the deferred branch; a live branch_taken is not meaningful here.
      do_branch = 1'b1;
      pend_d    = 1'b0;
      state_d   = ST_RUN;
    end else begin
      // Normal RUN rules, also used on the cycle a freeze releases.
      state_d = ((state_q == ST_FREEZE) && pend_q) ? ST_REPLAY : ST_RUN;
      if (branch_taken) begin
        do_branch = 1'b1;
      end else if (load_use) begin
        do_stall = 1'b1;
      end else begin
        PC_write   = 1'b1;
        IFID_write = 1'b1;
      end
    end

    // IF/ID ignores Flush unless Write is high, so a branch drives both.
    if (do_branch) begin
      PC_write   = 1'b1;
      IFID_write = 1'b1;
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end
    if (do_stall) begin
      IDEX_flush = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Counters and watchdog next values
  // --------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (do_stall && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + C_CNT_ONE;
    end
    if (do_branch && (flush_cnt_q != C_CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + C_CNT_ONE;
    end

    // Length of the current freeze run, saturating so it can never wrap
    // back below the threshold.
    if (freeze) begin
      frun_d = (frun_q == 8'hFF) ? frun_q : (frun_q + 8'd1);
    end else begin
      frun_d = 8'd0;
    end
    timeout_d = timeout_q | (frun_d >= C_MAX_FREEZE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pend_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      frun_q      <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      frun_q      <= frun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl. Two instances share the
//            same stimulus: one with default parameters and one with
//            CNT_W=2, MAX_FREEZE=4 for the saturation and watchdog cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mr, use2, br, busy;
  logic [4:0] rd, rs1, rs2;

  logic        pw_a, ifw_a, iff_a, idf_a, frz_a, to_a;
  logic [15:0] stall_a, flush_a;
  logic        pw_b, ifw_b, iff_b, idf_b, frz_b, to_b;
  logic [1:0]  stall_b, flush_b;

  hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .IDEX_MemRead(mr), .IDEX_rd(rd),
    .IFID_rs1(rs1), .IFID_rs2(rs2), .IFID_use_rs2(use2),
    .branch_taken(br), .dmem_busy(busy),
    .PC_write(pw_a), .IFID_write(ifw_a), .IFID_flush(iff_a),
    .IDEX_flush(idf_a), .freeze(frz_a),
    .stall_cnt(stall_a), .flush_cnt(flush_a), .timeout(to_a)
  );

  hazard_ctrl #(.CNT_W(2), .MAX_FREEZE(4)) dut_b (
    .clk(clk), .rst(rst), .IDEX_MemRead(mr), .IDEX_rd(rd),
    .IFID_rs1(rs1), .IFID_rs2(rs2), .IFID_use_rs2(use2),
    .branch_taken(br), .dmem_busy(busy),
    .PC_write(pw_b), .IFID_write(ifw_b), .IFID_flush(iff_b),
    .IDEX_flush(idf_b), .freeze(frz_b),
    .stall_cnt(stall_b), .flush_cnt(flush_b), .timeout(to_b)
  );

  // Control patterns {PC_write, IFID_write, IFID_flush, IDEX_flush, freeze}
  localparam logic [4:0] E_ZERO = 5'b00000;
  localparam logic [4:0] E_NORM = 5'b11000;
  localparam logic [4:0] E_LU   = 5'b00010;
  localparam logic [4:0] E_BR   = 5'b11110;
  localparam logic [4:0] E_FRZ  = 5'b00001;

  typedef struct {
    logic       rst;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use2;
    logic       br;
    logic       busy;
    logic [4:0] want;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model state (event-history view, no FSM states)
  int m_stall, m_flush, m_run;
  bit m_pend, m_replay, m_prevbusy, m_to_a, m_to_b;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic vec_t mk(input logic r, input logic m, input int d, input int s1,
                              input int s2, input logic u, input logic b,
                              input logic bz, input logic [4:0] w);
    vec_t v;
    v.rst = r; v.mr = m; v.rd = 5'(d); v.rs1 = 5'(s1); v.rs2 = 5'(s2);
    v.use2 = u; v.br = b; v.busy = bz; v.want = w;
    return v;
  endfunction

  // Expected controls from the current inputs and the model's history.
  function automatic logic [4:0] model_ctrl();
    bit hz;
    hz = mr && (rd != 5'd0) && ((rd == rs1) || (use2 && (rd == rs2)));
    if (rst)           return E_ZERO;
    else if (busy)     return E_FRZ;
    else if (m_replay) return E_BR;
    else if (br)       return E_BR;
    else if (hz)       return E_LU;
    else               return E_NORM;
  endfunction

  task automatic model_step(input logic [4:0] ctl);
    if (rst) begin
      m_stall = 0; m_flush = 0; m_run = 0;
      m_pend = 0; m_replay = 0; m_prevbusy = 0; m_to_a = 0; m_to_b = 0;
    end else begin
      if (ctl == E_LU) m_stall++;
      if (ctl == E_BR) m_flush++;
      if (busy) begin
        m_pend   = m_pend | br;
        m_replay = 0;
      end else if (m_replay) begin
        m_replay = 0;
        m_pend   = 0;
      end else begin
        // A freeze just ended: owe a flush if a branch arrived during it.
        m_replay = m_prevbusy && m_pend;
      end
      m_prevbusy = busy;
      m_run = busy ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
      if (m_run >= 64) m_to_a = 1;
      if (m_run >= 4)  m_to_b = 1;
    end
  endtask

  task automatic apply(input vec_t v, input bit has_want);
    logic [4:0] e;
    rst = v.rst; mr = v.mr; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    use2 = v.use2; br = v.br; busy = v.busy;
    #4;
    e = model_ctrl();
    chk("ctrl_a", int'({pw_a, ifw_a, iff_a, idf_a, frz_a}), int'(e));
    chk("ctrl_b", int'({pw_b, ifw_b, iff_b, idf_b, frz_b}), int'(e));
    if (has_want) chk("ctrl_vec", int'({pw_a, ifw_a, iff_a, idf_a, frz_a}), int'(v.want));
    model_step(e);
    @(posedge clk);
    #1;
    chk("stall_a", int'(stall_a), sat(m_stall, 16));
    chk("flush_a", int'(flush_a), sat(m_flush, 16));
    chk("stall_b", int'(stall_b), sat(m_stall, 2));
    chk("flush_b", int'(flush_b), sat(m_flush, 2));
    chk("timeout_a", int'(to_a), int'(m_to_a));
    chk("timeout_b", int'(to_b), int'(m_to_b));
  endtask

  vec_t tbl[10];
  vec_t v;
  vec_t v_rst, v_idle, v_lu;
  int   burst;

  initial begin
    rst = 1'b1; mr = 1'b0; rd = '0; rs1 = '0; rs2 = '0;
    use2 = 1'b0; br = 1'b0; busy = 1'b0;
    m_stall = 0; m_flush = 0; m_run = 0;
    m_pend = 0; m_replay = 0; m_prevbusy = 0; m_to_a = 0; m_to_b = 0;

    v_rst  = mk(1, 0, 0, 0, 0, 0, 0, 0, E_ZERO);
    v_idle = mk(0, 0, 0, 1, 2, 0, 0, 0, E_NORM);
    v_lu   = mk(0, 1, 5, 5, 0, 0, 0, 0, E_LU);

    // Directed vectors: reset, load-use forms, x0, branch priority, freeze
    tbl[0] = mk(1, 1, 5, 5, 0, 0, 1, 1, E_ZERO);
    tbl[1] = mk(0, 0, 3, 3, 0, 0, 0, 0, E_NORM);
    tbl[2] = mk(0, 1, 5, 5, 0, 0, 0, 0, E_LU);
    tbl[3] = mk(0, 1, 0, 0, 0, 0, 0, 0, E_NORM);
    tbl[4] = mk(0, 1, 7, 3, 7, 1, 0, 0, E_LU);
    tbl[5] = mk(0, 1, 7, 3, 7, 0, 0, 0, E_NORM);
    tbl[6] = mk(0, 1, 5, 5, 0, 0, 1, 0, E_BR);
    tbl[7] = mk(0, 1, 5, 5, 0, 0, 0, 1, E_FRZ);
    tbl[8] = mk(0, 0, 5, 5, 0, 0, 0, 0, E_NORM);
    tbl[9] = mk(0, 1, 9, 1, 9, 1, 0, 0, E_LU);

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i], 1'b1);
      if (i == 0) begin
        chk("rst_stall", int'(stall_a), 0);
        chk("rst_timeout", int'(to_b), 0);
      end
      if (i == 2) chk("lu_stall_1", int'(stall_a), 1);
      if (i == 3) chk("x0_stall_kept", int'(stall_a), 1);
      if (i == 6) begin
        chk("br_lu_flush", int'(flush_a), 1);
        chk("br_lu_stall", int'(stall_a), 2);
      end
    end

    // Branch during freeze, replayed after release
    apply(v_rst, 1'b1);
    apply(mk(0, 0, 0, 1, 2, 0, 0, 1, E_FRZ), 1'b1);
    apply(mk(0, 0, 0, 1, 2, 0, 1, 1, E_FRZ), 1'b1);
    apply(mk(0, 0, 0, 1, 2, 0, 0, 1, E_FRZ), 1'b1);
    apply(v_idle, 1'b1);
    apply(mk(0, 0, 0, 1, 2, 0, 0, 0, E_BR), 1'b1);
    apply(v_idle, 1'b1);
    chk("replay_flush_cnt", int'(flush_a), 1);

    // Replay interrupted by a new freeze still replays afterwards
    apply(mk(0, 0, 0, 1, 2, 0, 1, 1, E_FRZ), 1'b1);
    apply(v_idle, 1'b1);
    apply(mk(0, 0, 0, 1, 2, 0, 0, 1, E_FRZ), 1'b1);
    apply(v_idle, 1'b1);
    apply(mk(0, 0, 0, 1, 2, 0, 0, 0, E_BR), 1'b1);

    // Reset mid-freeze and mid-replay discards the pending branch
    apply(mk(0, 0, 0, 1, 2, 0, 1, 1, E_FRZ), 1'b1);
    apply(v_rst, 1'b1);
    apply(v_idle, 1'b1);
    apply(v_idle, 1'b1);
    apply(mk(0, 0, 0, 1, 2, 0, 1, 1, E_FRZ), 1'b1);
    apply(v_idle, 1'b1);
    apply(v_rst, 1'b1);
    apply(v_idle, 1'b1);

    // Watchdog with MAX_FREEZE=4 on dut_b
    apply(v_rst, 1'b1);
    for (int i = 0; i < 6; i++) begin
      apply(mk(0, 0, 0, 1, 2, 0, 0, 1, E_FRZ), 1'b1);
      if (i == 2) chk("wd_before", int'(to_b), 0);
      if (i == 3) chk("wd_at_4th", int'(to_b), 1);
    end
    apply(v_idle, 1'b1);
    apply(v_idle, 1'b1);
    chk("wd_sticky", int'(to_b), 1);
    chk("wd_no_effect", int'({pw_b, ifw_b, iff_b, idf_b, frz_b}), int'(E_NORM));
    apply(v_rst, 1'b1);
    chk("wd_cleared", int'(to_b), 0);

    // Counter saturation with CNT_W=2
    for (int i = 0; i < 6; i++) apply(v_lu, 1'b1);
    chk("sat_b", int'(stall_b), 3);
    chk("nosat_a", int'(stall_a), 6);

    // Randomized traffic against the reference model
    burst = 0;
    for (int i = 0; i < 800; i++) begin
      if (burst > 0) burst--;
      else if ($urandom_range(0, 19) == 0) burst = int'($urandom_range(3, 8));
      v.busy = (burst > 0) || ($urandom_range(0, 7) == 0);
      v.rst  = ($urandom_range(0, 149) == 0);
      v.mr   = 1'($urandom_range(0, 1));
      v.rd   = 5'($urandom_range(0, 3));
      v.rs1  = 5'($urandom_range(0, 3));
      v.rs2  = 5'($urandom_range(0, 3));
      v.use2 = 1'($urandom_range(0, 1));
      v.br   = ($urandom_range(0, 5) == 0);
      v.want = E_ZERO;
      apply(v, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
